// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - note pattern fetch/decode responder with jump following
// Fetches ROM entries on enable, follows JUMP entries, returns one decoded note per request.
module pattern_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int START_ADDR = 0,
  parameter int MAX_JUMPS  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_restart,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic [5:0]            o_pitch,
  output logic [7:0]            o_duration,
  output logic                  o_rest,
  output logic                  o_end,
  output logic                  o_fault,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  output logic                  o_rom_rd,
  input  logic [15:0]           i_rom_data
);

  localparam int JW = (MAX_JUMPS < 1) ? 1 : $clog2(MAX_JUMPS + 1);
  localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);
  localparam logic [JW-1:0]         JMAX  = JW'(MAX_JUMPS);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

  localparam logic [1:0] OP_NOTE = 2'b00;
  localparam logic [1:0] OP_REST = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_HALT, S_FAULT} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [JW-1:0]         r_jump_cnt;
  logic                  r_halt_pend;

  logic [1:0]            w_op;
  logic [ADDR_WIDTH-1:0] w_target;

  assign w_op     = i_rom_data[15:14];
  assign w_target = i_rom_data[ADDR_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= START;
      r_jump_cnt  <= '0;
      r_halt_pend <= 1'b0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_pitch     <= '0;
      o_duration  <= '0;
      o_rest      <= 1'b0;
      o_end       <= 1'b0;
      o_fault     <= 1'b0;
      o_rom_addr  <= '0;
      o_rom_rd    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_restart) begin
            r_ptr <= START;
          end else if (i_enable) begin
            r_state    <= S_FETCH;
            o_busy     <= 1'b1;
            o_rom_rd   <= 1'b1;
            o_rom_addr <= r_ptr;
          end
        end
        S_FETCH: begin
          o_rom_rd <= 1'b0;
          if (i_restart) begin
            r_state    <= S_IDLE;
            r_ptr      <= START;
            r_jump_cnt <= '0;
            o_busy     <= 1'b0;
          end else begin
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (i_restart) begin
            r_state    <= S_IDLE;
            r_ptr      <= START;
            r_jump_cnt <= '0;
            o_busy     <= 1'b0;
          end else if (w_op == OP_NOTE || w_op == OP_REST) begin
            o_pitch    <= (w_op == OP_NOTE) ? i_rom_data[13:8] : 6'd0;
            o_duration <= i_rom_data[7:0];
            o_rest     <= (w_op == OP_REST);
            o_end      <= 1'b0;
            o_valid    <= 1'b1;
            o_busy     <= 1'b0;
            r_ptr      <= r_ptr + ONE;
            r_jump_cnt <= '0;
            r_state    <= S_IDLE;
          end else if (w_op == OP_JUMP) begin
            if (r_jump_cnt == JMAX) begin
              r_state <= S_FAULT;
              o_fault <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              // Jump re-enters FETCH with the read already issued to the target.
              r_ptr      <= w_target;
              r_jump_cnt <= r_jump_cnt + 1'b1;
              r_state    <= S_FETCH;
              o_rom_rd   <= 1'b1;
              o_rom_addr <= w_target;
            end
          end else begin
            o_pitch    <= '0;
            o_duration <= '0;
            o_rest     <= 1'b1;
            o_end      <= 1'b1;
            o_valid    <= 1'b1;
            o_busy     <= 1'b0;
            r_jump_cnt <= '0;
            r_state    <= S_HALT;
          end
        end
        S_HALT: begin
          if (i_restart) begin
            r_state     <= S_IDLE;
            r_ptr       <= START;
            r_halt_pend <= 1'b0;
            o_busy      <= 1'b0;
            o_end       <= 1'b0;
          end else if (r_halt_pend) begin
            r_halt_pend <= 1'b0;
            o_valid     <= 1'b1;
            o_busy      <= 1'b0;
            o_pitch     <= '0;
            o_duration  <= '0;
            o_rest      <= 1'b1;
            o_end       <= 1'b1;
          end else if (i_enable) begin
            r_halt_pend <= 1'b1;
            o_busy      <= 1'b1;
          end
        end
        S_FAULT: begin
          if (i_restart) begin
            r_state    <= S_IDLE;
            r_ptr      <= START;
            r_jump_cnt <= '0;
            o_fault    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed vector bench for pattern_sequencer
// Cycle table for the basic handshake plus hand sequences for halt, fault, reset and wrap.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic        o_valid, o_busy, o_rest, o_end, o_fault, o_rom_rd;
  logic [5:0]  o_pitch;
  logic [7:0]  o_duration;
  logic [7:0]  o_rom_addr;
  logic [15:0] rom_q = 16'h0;
  logic [15:0] rom [256];

  int checks = 0;
  int failures = 0;
  int vcnt = 0;
  int rdcnt = 0;

  always #5 clk = ~clk;

  pattern_sequencer #(.ADDR_WIDTH(8), .START_ADDR(0), .MAX_JUMPS(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_restart(restart),
    .o_valid(o_valid), .o_busy(o_busy), .o_pitch(o_pitch), .o_duration(o_duration),
    .o_rest(o_rest), .o_end(o_end), .o_fault(o_fault),
    .o_rom_addr(o_rom_addr), .o_rom_rd(o_rom_rd), .i_rom_data(rom_q)
  );

  always @(posedge clk) if (o_rom_rd) rom_q <= rom[o_rom_addr];

  always @(negedge clk) begin
    if (o_valid) vcnt++;
    if (o_rom_rd) rdcnt++;
  end

  typedef struct packed {
    logic       en, rs, v, b, rd;
    logic [7:0] a;
    logic [5:0] p;
    logic [7:0] d;
    logic       r, e, f;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic rs, input logic v, input logic b,
                              input logic rd, input logic [7:0] a, input logic [5:0] p,
                              input logic [7:0] d, input logic r, input logic e, input logic f);
    vec_t x;
    x.en = en; x.rs = rs; x.v = v; x.b = b; x.rd = rd;
    x.a = a; x.p = p; x.d = d; x.r = r; x.e = e; x.f = f;
    return x;
  endfunction

  function automatic logic [27:0] act_bits();
    return {o_valid, o_busy, o_rom_rd, o_rom_addr, o_pitch, o_duration, o_rest, o_end, o_fault};
  endfunction

  task automatic chk_out(input string nm, input vec_t x);
    logic [27:0] exp_b;
    logic [27:0] act_b;
    exp_b = {x.v, x.b, x.rd, x.a, x.p, x.d, x.r, x.e, x.f};
    act_b = act_bits();
    checks++;
    if (act_b !== exp_b) begin
      failures++;
      $display("FAIL %s act{v,b,rd,a,p,d,r,e,f}=%h required=%h", nm, act_b, exp_b);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s act=%0d required=%0d", nm, act, exp_v);
    end
  endtask

  task automatic tick(input logic en, input logic rs);
    enable = en;
    restart = rs;
    @(posedge clk);
    #1;
    enable = 1'b0;
    restart = 1'b0;
  endtask

  vec_t vt[$];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2A10;
    rom[1] = 16'h4008;
    rom[2] = 16'h8000;

    // fields:     en    rs    v     b     rd    addr   pitch  dur     rest  end   fault
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 6'd0,  8'd0,  1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0,  8'd0,  1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6'd42, 8'd16, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'd42, 8'd16, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 6'd42, 8'd16, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 6'd42, 8'd16, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 6'd0,  8'd8,  1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 6'd0,  8'd8,  1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 6'd0,  8'd8,  1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 6'd0,  8'd8,  1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 6'd0,  8'd8,  1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0,  8'd8,  1'b1, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6'd42, 8'd16, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd42, 8'd16, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'd42, 8'd16, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 6'd42, 8'd16, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 6'd42, 8'd16, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6'd42, 8'd16, 1'b0, 1'b0, 1'b0));

    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk_out("reset_state", mk(0, 0, 0, 0, 0, 8'h00, 6'd0, 8'd0, 0, 0, 0));
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    chk_out("after_reset_release", mk(0, 0, 0, 0, 0, 8'h00, 6'd0, 8'd0, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      tick(vt[i].en, vt[i].rs);
      chk_out($sformatf("vec%0d", i), vt[i]);
    end

    // END entry, then halted enable served without a ROM read
    rom[1] = 16'hC000;
    tick(1'b1, 1'b0);
    chk_out("end_fetch",   mk(0, 0, 0, 1, 1, 8'h01, 6'd42, 8'd16, 0, 0, 0));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_out("end_valid",   mk(0, 0, 1, 0, 0, 8'h01, 6'd0, 8'd0, 1, 1, 0));
    tick(1'b0, 1'b0);
    chk_out("end_hold",    mk(0, 0, 0, 0, 0, 8'h01, 6'd0, 8'd0, 1, 1, 0));
    tick(1'b1, 1'b0);
    chk_out("halt_busy",   mk(0, 0, 0, 1, 0, 8'h01, 6'd0, 8'd0, 1, 1, 0));
    tick(1'b0, 1'b0);
    chk_out("halt_valid",  mk(0, 0, 1, 0, 0, 8'h01, 6'd0, 8'd0, 1, 1, 0));
    tick(1'b0, 1'b1);
    chk_out("halt_restart", mk(0, 0, 0, 0, 0, 8'h01, 6'd0, 8'd0, 1, 0, 0));
    tick(1'b1, 1'b0);
    chk_out("post_halt_fetch", mk(0, 0, 0, 1, 1, 8'h00, 6'd0, 8'd0, 1, 0, 0));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_out("post_halt_note", mk(0, 0, 1, 0, 0, 8'h00, 6'd42, 8'd16, 0, 0, 0));

    // four chained jumps exceed MAX_JUMPS=3
    rom[0] = 16'h800A; rom[10] = 16'h800B; rom[11] = 16'h800C; rom[12] = 16'h800D;
    tick(1'b0, 1'b1);
    vcnt = 0;
    rdcnt = 0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b0);
    chk_int("fault_no_valid", vcnt, 0);
    chk_int("fault_rd_count", rdcnt, 4);
    chk_out("fault_state", mk(0, 0, 0, 0, 0, 8'h0C, 6'd42, 8'd16, 0, 0, 1));
    tick(1'b1, 1'b0);
    chk_out("fault_ignores_enable", mk(0, 0, 0, 0, 0, 8'h0C, 6'd42, 8'd16, 0, 0, 1));
    tick(1'b0, 1'b1);
    chk_out("fault_cleared", mk(0, 0, 0, 0, 0, 8'h0C, 6'd42, 8'd16, 0, 0, 0));
    tick(1'b1, 1'b0);
    chk_out("fault_refetch_start", mk(0, 0, 0, 1, 1, 8'h00, 6'd42, 8'd16, 0, 0, 0));
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_int("abort_fetch_no_valid", vcnt, 0);
    chk_out("abort_fetch_idle", mk(0, 0, 0, 0, 0, 8'h00, 6'd42, 8'd16, 0, 0, 0));

    // reset while the fetch is in DECODE
    rom[0] = 16'h2A10;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    rst_n = 1'b0;
    tick(1'b0, 1'b0);
    chk_out("reset_in_decode", mk(0, 0, 0, 0, 0, 8'h00, 6'd0, 8'd0, 0, 0, 0));
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_int("reset_in_decode_no_valid", vcnt, 0);

    // pointer wrap: jump to 255, NOTE there, next fetch reads 0
    rom[0] = 16'h80FF;
    rom[255] = 16'h1105;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_out("jump_to_255", mk(0, 0, 0, 1, 1, 8'hFF, 6'd0, 8'd0, 0, 0, 0));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_out("note_at_255", mk(0, 0, 1, 0, 0, 8'hFF, 6'd17, 8'd5, 0, 0, 0));
    tick(1'b1, 1'b0);
    chk_out("wrap_fetch_0", mk(0, 0, 0, 1, 1, 8'h00, 6'd17, 8'd5, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
